// File: rtl/stream_demux.sv
// stream_demux: one-to-N valid/ready stream demultiplexer.
// Each of the N_OUT = 2**SEL_W output channels owns a single holding register.
// A word is steered to the channel named by in_sel. Each channel stalls
// independently, and a slot can drain and refill in the same cycle, so each
// channel sustains one word per cycle.
// Optional feature: define STREAM_DEMUX_BCAST_EN to enable broadcast.
// With broadcast enabled, in_bcast=1 writes the word into every channel at once.
// Without the macro, in_bcast is accepted on the port but has no effect.
module stream_demux #(
    parameter int  DATA_W = 8,
    parameter int  SEL_W  = 4,
    localparam int N_OUT  = 2 ** SEL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    busy
);

    // Per-channel holding registers.
    logic              r_valid [N_OUT];
    logic [DATA_W-1:0] r_data  [N_OUT];

    // Slot k is free when it is empty or is being drained in this cycle.
    logic [N_OUT-1:0]  w_free;
    // Slot k is the target of the current input word (selected, or broadcast).
    logic [N_OUT-1:0]  w_hit;
    logic              w_bcast;
    logic              w_accept;

`ifdef STREAM_DEMUX_BCAST_EN
    assign w_bcast = in_bcast;
`else
    // Broadcast is not built, so the request is treated as unicast.
    logic w_unused_bcast;
    assign w_unused_bcast = in_bcast;
    assign w_bcast        = 1'b0;
`endif

    // Decode the free and target flags for each channel.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_flags
            assign w_free[gi] = ~r_valid[gi] | out_ready[gi];
            assign w_hit[gi]  = w_bcast | (in_sel == SEL_W'(gi));
        end
    endgenerate

    // in_ready is derived from state, in_sel, out_ready and in_bcast only.
    // It never depends on in_valid, and it is held low during reset.
    // A broadcast needs every slot free. A unicast needs only the addressed slot.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (w_bcast) begin
                in_ready = &w_free;
            end else begin
                in_ready = w_free[in_sel];
            end
        end
    end

    assign w_accept = in_valid & in_ready;

    // Channel registers. A load takes priority over a drain, so a slot that is
    // drained and refilled in the same cycle keeps valid high and shows the
    // new word.
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_chan
            // Holding register for channel gi.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else if (w_accept && w_hit[gi]) begin
                    r_valid[gi] <= 1'b1;
                    r_data[gi]  <= in_data;
                end else if (out_ready[gi]) begin
                    r_valid[gi] <= 1'b0;
                end
            end

            assign out_valid[gi]                    = r_valid[gi];
            assign out_data[gi*DATA_W +: DATA_W]    = r_data[gi];
        end
    endgenerate

    // busy is derived purely from the valid registers.
    assign busy = |out_valid;

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux.
// It runs directed scenarios with literal expectations, then randomized
// traffic. A per-channel occupancy model inside the bench is checked against
// the DUT on every cycle.
module tb_stream_demux;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int N  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic            in_bcast;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic            busy;

    stream_demux #(.DATA_W(DW), .SEL_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_bcast (in_bcast),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // Model: each channel is a queue with capacity one.
    // Word count per channel (0 or 1), and the word held.
    int          mdl_cnt  [N];
    logic [DW-1:0] mdl_word [N];
    bit          mdl_known = 1'b0;

    task automatic expect_eq(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit bcast_eff();
`ifdef STREAM_DEMUX_BCAST_EN
        return in_bcast;
`else
        return 1'b0;
`endif
    endfunction

    // Model's view of whether the input is accepted this cycle.
    function automatic bit model_ready();
        bit all_free;
        if (rst) return 1'b0;
        all_free = 1'b1;
        for (int k = 0; k < N; k++)
            if (mdl_cnt[k] != 0 && !out_ready[k]) all_free = 1'b0;
        if (bcast_eff()) return all_free;
        return (mdl_cnt[in_sel] == 0) || out_ready[in_sel];
    endfunction

    // Compare all DUT outputs against the model (inputs stable, mid-cycle).
    task automatic model_check();
        logic [N-1:0] exp_v;
        int nwrong;
        if (!mdl_known) return;
        exp_v = '0;
        nwrong = 0;
        for (int k = 0; k < N; k++) begin
            exp_v[k] = (mdl_cnt[k] != 0);
            if (exp_v[k] && out_data[k*DW +: DW] !== mdl_word[k]) begin
                nwrong++;
                if (nwrong == 1)
                    $display("FAIL model_data ch=%0d actual=%0h required=%0h",
                             k, out_data[k*DW +: DW], mdl_word[k]);
            end
        end
        checks++;
        if (nwrong != 0) errors++;
        expect_eq("model_out_valid", 128'(out_valid), 128'(exp_v));
        expect_eq("model_busy", 128'(busy), 128'(exp_v != 0));
        expect_eq("model_in_ready", 128'(in_ready), 128'(model_ready()));
    endtask

    // Apply one clock edge to the model.
    task automatic model_update(input bit rdy);
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mdl_cnt[k]  = 0;
                mdl_word[k] = '0;
            end
            mdl_known = 1'b1;
            return;
        end
        if (!mdl_known) return;
        // Drain first, then fill: the slot is a capacity-one queue.
        for (int k = 0; k < N; k++) begin
            if (mdl_cnt[k] != 0 && out_ready[k]) begin
                if (verbose) $display("out  ch=%0d data=%02h", k, mdl_word[k]);
                mdl_cnt[k] = 0;
            end
        end
        if (in_valid && rdy) begin
            for (int k = 0; k < N; k++) begin
                if (bcast_eff() || in_sel == SW'(k)) begin
                    mdl_cnt[k]++;
                    mdl_word[k] = in_data;
                end
            end
            if (verbose) $display("in   sel=%0d bcast=%0b data=%02h", in_sel, bcast_eff(), in_data);
        end
    endtask

    // One clock cycle: check mid-cycle, advance model at the edge, return 1ns after.
    task automatic cycle();
        bit rdy;
        @(negedge clk);
        model_check();
        rdy = model_ready();
        @(posedge clk);
        model_update(rdy);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h11; in_sel = 4'h2;
        in_bcast = 1'b0; out_ready = '0;
        #1;
        // Reset held two cycles with in_valid high.
        cycle();
        cycle();
        settle();
        expect_eq("reset_in_ready", 128'(in_ready), 128'(0));
        expect_eq("reset_out_valid", 128'(out_valid), 128'(16'h0000));
        expect_eq("reset_out_data", 128'(out_data), 128'(0));
        expect_eq("reset_busy", 128'(busy), 128'(0));

        // Unicast to channel 10, then a blocked second word.
        rst = 1'b0; in_valid = 1'b1; in_sel = 4'hA; in_data = 8'h5C; out_ready = '0;
        settle();
        expect_eq("first_cycle_ready", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0;
        settle();
        expect_eq("uni_out_valid", 128'(out_valid), 128'(16'h0400));
        expect_eq("uni_out_data", 128'(out_data[87:80]), 128'(8'h5C));
        in_valid = 1'b1; in_data = 8'h33;
        settle();
        expect_eq("uni_blocked_ready", 128'(in_ready), 128'(0));
        cycle();
        expect_eq("uni_still_blocked", 128'(in_ready), 128'(0));
        expect_eq("uni_data_stable", 128'(out_data[87:80]), 128'(8'h5C));
        out_ready[10] = 1'b1;
        settle();
        expect_eq("uni_unblocked_ready", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0; out_ready = '0;
        settle();
        expect_eq("uni_refill_valid", 128'(out_valid), 128'(16'h0400));
        expect_eq("uni_refill_data", 128'(out_data[87:80]), 128'(8'h33));
        out_ready = '1;
        cycle();
        expect_eq("uni_drained", 128'(out_valid), 128'(16'h0000));

        // Streaming: eight back-to-back words to channel 3.
        out_ready = '1; in_sel = 4'd3; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'h10 + 8'(i);
            settle();
            expect_eq("stream_ready", 128'(in_ready), 128'(1));
            cycle();
            expect_eq("stream_valid", 128'(out_valid), 128'(16'h0008));
            expect_eq("stream_data", 128'(out_data[31:24]), 128'(8'h10 + 8'(i)));
        end
        in_valid = 1'b0;
        cycle();
        expect_eq("stream_end", 128'(out_valid), 128'(16'h0000));

        // Independence: channel 0 stalled full, word to channel 1.
        out_ready = '0; in_valid = 1'b1; in_sel = 4'd0; in_data = 8'hA0;
        cycle();
        in_sel = 4'd1; in_data = 8'hA1;
        settle();
        expect_eq("indep_ready", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0;
        settle();
        expect_eq("indep_valid", 128'(out_valid), 128'(16'h0003));
        out_ready = '1;
        cycle();

        // Broadcast (or its absence in the default build).
        out_ready = '0; in_valid = 1'b1; in_bcast = 1'b1; in_sel = 4'd5; in_data = 8'hFF;
        settle();
        expect_eq("bcast_empty_ready", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0; in_bcast = 1'b0;
        settle();
`ifdef STREAM_DEMUX_BCAST_EN
        expect_eq("bcast_all_valid", 128'(out_valid), 128'(16'hFFFF));
        out_ready = '1;
        cycle();
        out_ready = '0; in_valid = 1'b1; in_sel = 4'd7; in_data = 8'h07;
        cycle();
        in_bcast = 1'b1; in_data = 8'hFF;
        settle();
        expect_eq("bcast_blocked", 128'(in_ready), 128'(0));
        cycle();
        expect_eq("bcast_still_blocked", 128'(in_ready), 128'(0));
        out_ready[7] = 1'b1;
        settle();
        expect_eq("bcast_unblocked", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
        settle();
        expect_eq("bcast_refill_valid", 128'(out_valid), 128'(16'hFFFF));
        expect_eq("bcast_ch7_data", 128'(out_data[63:56]), 128'(8'hFF));
`else
        expect_eq("bcast_ignored", 128'(out_valid), 128'(16'h0020));
`endif
        out_ready = '1;
        cycle();
        out_ready = '0;

        // Reset with channels 0 and 15 full.
        in_valid = 1'b1; in_sel = 4'd0; in_data = 8'hC0;
        cycle();
        in_sel = 4'd15; in_data = 8'hCF;
        cycle();
        in_valid = 1'b0;
        settle();
        expect_eq("mid_pre_valid", 128'(out_valid), 128'(16'h8001));
        rst = 1'b1; in_valid = 1'b1;
        settle();
        expect_eq("mid_rst_ready", 128'(in_ready), 128'(0));
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        settle();
        expect_eq("mid_rst_valid", 128'(out_valid), 128'(16'h0000));
        expect_eq("mid_rst_busy", 128'(busy), 128'(0));
        expect_eq("mid_rst_data", 128'(out_data), 128'(0));

        // Randomized traffic checked against the model every cycle.
        verbose = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, 3)) : SW'($urandom);
            in_data  = DW'($urandom);
            in_bcast = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < N; k++) out_ready[k] = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
